piso_seq_ctrl: RTL and testbench

PISO_SEQ_CTRL -- requirements
Module: piso_seq_ctrl

---
 rtl/piso_seq_pkg.sv | 30 +++
 rtl/piso_seq_xfer_bit_counter.sv | 31 +++
 rtl/piso_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_piso_seq_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_seq_pkg.sv
// Shared constants for the PISO sequencer: state encoding, PISO control pairs, default width.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Ports: none. This package is imported by piso_seq_ctrl and xfer_bit_counter.
package piso_seq_pkg;

    localparam int PISO_WIDTH_DEFAULT = 4;

    // FSM state encoding (2-bit, legacy-compatible constants)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // PISO control pair. latch_c is only meaningful while shift_c=1.
    typedef struct packed {
        logic shift_c;
        logic latch_c;
    } ctrl_t;

    localparam ctrl_t CTRL_HOLD  = 2'b00;
    localparam ctrl_t CTRL_LOAD  = 2'b10;
    localparam ctrl_t CTRL_SHIFT = 2'b11;

    // Counter width: wide enough to hold WIDTH without wrapping inside a transfer.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/piso_seq_xfer_bit_counter.sv
// Shift-cycle counter with synchronous clear/increment and terminal-count flag.
// Latency: count updates one edge after clr/inc; tc is combinational from the count.
// Backpressure: none; clr wins over inc.
// Ports: clk, rst (sync, active-high), clr, inc in; tc out (count == WIDTH-1).
import piso_seq_pkg::*;

module xfer_bit_counter #(
    parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_seq_ctrl.sv
// Sequencer that drives an external PISO: load a held word, shift WIDTH bits, capture them LSB-first.
// Latency: start at edge E0 -> done pulse in the cycle after edge E(WIDTH+1); start-to-start >= WIDTH+3.
// Backpressure: start is only sampled in IDLE; requests while busy/done are dropped, never queued.
// Ports: clk, rst (sync, active-high), start, data_in[WIDTH], c in;
//        pdata[WIDTH], latch_c, shift_c, busy, done, result[WIDTH], parity out.
// Build option: define PISO_SEQ_PARITY_EN to generate the result parity register (else parity=0).
import piso_seq_pkg::*;

module piso_seq_ctrl #(
    parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             c,
    output logic [WIDTH-1:0] pdata,
    output logic             latch_c,
    output logic             shift_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             parity
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept;
    logic             last_shift;
    logic [WIDTH:0]   result_ext;
    logic [WIDTH-1:0] result_nxt;
    ctrl_t            ctrl;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign accept = (state == ST_IDLE) && start;

    // ------------------------------------------------------ shift counter
    xfer_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_LOAD),
        .inc (state == ST_SHIFT),
        .tc  (last_shift)
    );

    // ----------------------------------------------------------- datapath
    // Word is captured only on the accepting edge so later data_in changes
    // cannot disturb a transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pdata <= '0;
        end else if (accept) begin
            pdata <= data_in;
        end
    end

    // Serial bit enters at the MSB and walks down; after WIDTH shifts the
    // first bit out of the PISO (its LSB) sits in result[0]. Built as a
    // right-shift of {c, result} so WIDTH=1 needs no special case.
    assign result_ext = {c, result};
    assign result_nxt = result_ext[WIDTH:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (state == ST_SHIFT) begin
            result <= result_nxt;
        end
    end

`ifdef PISO_SEQ_PARITY_EN
    // Updated together with the final shift, then held like result.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if ((state == ST_SHIFT) && last_shift) begin
            parity <= ^result_nxt;
        end
    end
`else
    assign parity = 1'b0;
`endif

    // ----------------------------------------------------- control decode
    always_comb begin
        ctrl = CTRL_HOLD;
        case (state)
            ST_LOAD:  ctrl = CTRL_LOAD;
            ST_SHIFT: ctrl = CTRL_SHIFT;
            default:  ctrl = CTRL_HOLD;
        endcase
    end

    assign shift_c = ctrl.shift_c;
    assign latch_c = ctrl.latch_c;
    assign busy    = (state == ST_LOAD) || (state == ST_SHIFT);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_piso_seq_ctrl.sv
module tb_piso_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         c;
    logic [W-1:0] pdata;
    logic         latch_c, shift_c, busy, done, parity;
    logic [W-1:0] result;

    // second instance, WIDTH=8, directed check only
    logic         rst8 = 1'b1;
    logic         start8 = 1'b0;
    logic [7:0]   data8 = '0;
    logic         c8;
    logic [7:0]   pdata8;
    logic         latch8, shift8, busy8, done8, parity8;
    logic [7:0]   result8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_seq_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .c(c),
        .pdata(pdata), .latch_c(latch_c), .shift_c(shift_c), .busy(busy),
        .done(done), .result(result), .parity(parity)
    );

    piso_seq_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .data_in(data8), .c(c8),
        .pdata(pdata8), .latch_c(latch8), .shift_c(shift8), .busy(busy8),
        .done(done8), .result(result8), .parity(parity8)
    );

    // External PISO models: load when shift_c=1/latch_c=0, shift right when both 1.
    logic [W-1:0] piso = '0;
    logic [7:0]   piso8 = '0;
    always @(posedge clk) begin
        if (shift_c) piso <= latch_c ? (piso >> 1) : pdata;
        if (shift8)  piso8 <= latch8 ? (piso8 >> 1) : pdata8;
    end
    assign c  = piso[0];
    assign c8 = piso8[0];

    function automatic logic exp_par(input logic [W-1:0] d);
`ifdef PISO_SEQ_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------ reference model
    // Transaction-level view: an accepted request occupies the block for
    // W+3 edges, done appears W+1 edges after acceptance, and the result is
    // simply the accepted word.
    typedef struct {
        int           done_edge;
        logic [W-1:0] res;
    } exp_t;

    exp_t         exp_q[$];
    int           edge_n = 0;
    int           free_edge = 0;
    int           acc_edge = 0;
    logic [W-1:0] acc_data = '0;
    bit           in_flight = 0;
    bit           rst_seen = 0;
    logic [W-1:0] last_res = '0;
    logic         last_par = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            if (in_flight && edge_n <= acc_edge + W + 1 && exp_q.size() > 0)
                void'(exp_q.pop_back());
            in_flight = 0;
            last_res  = '0;
            last_par  = 1'b0;
            free_edge = edge_n + 1;
            rst_seen  = 1;
        end else begin
            rst_seen = 0;
            if (in_flight && edge_n == acc_edge + W + 1) begin
                last_res = acc_data;
                last_par = exp_par(acc_data);
            end
            if (in_flight && edge_n >= acc_edge + W + 2) in_flight = 0;
            if (start && edge_n >= free_edge) begin
                acc_edge  = edge_n;
                acc_data  = data_in;
                in_flight = 1;
                free_edge = edge_n + W + 3;
                exp_q.push_back('{edge_n + W + 1, data_in});
            end
        end
    end

    // ------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (edge_n > 0) begin
            if (rst_seen) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ctrl", {shift_c, latch_c}, 0);
                chk("rst_pdata", pdata, 0);
                chk("rst_result", result, 0);
                chk("rst_parity", parity, 0);
            end else begin
                int  ph;
                ph = in_flight ? (edge_n - acc_edge) : -1;
                chk("busy", busy, (ph >= 0 && ph <= W));
                chk("done", done, (ph == W + 1));
                chk("ctrl", {shift_c, latch_c}, {(ph >= 0 && ph <= W), (ph >= 1 && ph <= W)});
                chk("parity_hold", parity, last_par);
                if (ph >= 0) chk("pdata_hold", pdata, acc_data);
                if (!(ph >= 2 && ph <= W)) chk("result_hold", result, last_res);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sb_latency", edge_n, e.done_edge);
                        chk("sb_result", result, e.res);
                        chk("sb_parity", parity, exp_par(e.res));
                    end
                end
            end
        end
    end

    // ------------------------------------------------------- stimulus
    task automatic cyc(input logic s, input logic r, input logic [W-1:0] d);
        @(negedge clk);
        #1;
        start   = s;
        rst     = r;
        data_in = d;
    endtask

    initial begin
        int lat, nshift;
        bit got;
        // reset
        repeat (3) cyc(0, 1, 4'hA);
        // basic transfer 1011
        cyc(1, 0, 4'b1011);
        repeat (8) cyc(0, 0, 4'h0);
        // start held high: one transfer per IDLE visit, 7-cycle spacing
        for (int i = 0; i < 16; i++) cyc(1, 0, 4'($urandom));
        repeat (8) cyc(0, 0, 4'h0);
        // reset during second SHIFT cycle, start asserted alongside rst
        cyc(1, 0, 4'b1001);
        cyc(0, 0, 4'h0);
        cyc(0, 0, 4'h0);
        cyc(1, 1, 4'h3);
        cyc(1, 0, 4'b0110);
        repeat (8) cyc(0, 0, 4'h0);
        // data_in changes after acceptance
        cyc(1, 0, 4'b1111);
        repeat (8) cyc(0, 0, 4'b0000);
        cyc(1, 0, 4'b0001);
        repeat (8) cyc(0, 0, 4'h0);
        // randomized traffic
        for (int i = 0; i < 1500; i++)
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0), 4'($urandom));
        repeat (10) cyc(0, 0, 4'h0);
        chk("sb_drained", exp_q.size(), 0);

        // WIDTH=8 transfer of 8'hA5
        @(negedge clk); #1; rst8 = 1'b0; start8 = 1'b1; data8 = 8'hA5;
        @(posedge clk);
        lat = 0; nshift = 0; got = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin start8 = 1'b0; data8 = 8'h00; end
            if (shift8 && latch8) nshift++;
            if (done8) begin got = 1; lat = i; end
        end
        chk("w8_latency", lat, 10);
        chk("w8_shifts", nshift, 8);
        chk("w8_result", result8, 8'hA5);
        chk("w8_parity", parity8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
